alu_seq_mul: RTL and testbench



---
 rtl/alu_mul_pkg.sv | 18 +
 rtl/mul_sign_conv.sv | 82 ++++++++
 rtl/alu_seq_mul.sv | 110 +++++++++++
 tb/tb_alu_seq_mul.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_pkg.sv
// rtl/alu_mul_pkg.sv - shared mode encodings, FSM states and iteration count for alu_seq_mul
package alu_mul_pkg;

  localparam logic [1:0] MUL_UNS = 2'b00;
  localparam logic [1:0] MUL_TC  = 2'b01;
  localparam logic [1:0] MUL_SM  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  function automatic int iter_count(input int width, input int bpc);
    return width / bpc;
  endfunction

endpackage

// File: rtl/mul_sign_conv.sv
// rtl/mul_sign_conv.sv - operand magnitude/sign extraction and result format restoration
// Saturation of the fixed-point result is built only with ALU_SEQ_MUL_SAT_EN defined.
module mul_sign_conv
  import alu_mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12
) (
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sign_in,
  input  logic [2*WIDTH-1:0] acc,
  output logic [WIDTH-1:0]   mag_a,
  output logic [WIDTH-1:0]   mag_b,
  output logic               sign_out,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   fixed,
  output logic               overflow
);

  always_comb begin
    mag_a    = a;
    mag_b    = b;
    sign_out = 1'b0;
    case (mode)
      MUL_TC: begin
        mag_a    = a[WIDTH-1] ? -a : a;
        mag_b    = b[WIDTH-1] ? -b : b;
        sign_out = a[WIDTH-1] ^ b[WIDTH-1];
      end
      MUL_SM: begin
        mag_a    = {1'b0, a[WIDTH-2:0]};
        mag_b    = {1'b0, b[WIDTH-2:0]};
        sign_out = a[WIDTH-1] ^ b[WIDTH-1];
      end
      default: ;
    endcase
    // a zero product never carries a sign
    if (mag_a == '0 || mag_b == '0) sign_out = 1'b0;
  end

  always_comb begin
    product  = acc;
    fixed    = acc[FRAC+WIDTH-1:FRAC];
    overflow = 1'b0;
    case (mode)
      MUL_TC: begin
        product = sign_in ? -acc : acc;
        fixed   = product[FRAC+WIDTH-1:FRAC];
      end
      MUL_SM: begin
        product = {sign_in, acc[2*WIDTH-2:0]};
        fixed   = {sign_in, acc[FRAC+WIDTH-2:FRAC]};
      end
      default: ;
    endcase
`ifdef ALU_SEQ_MUL_SAT_EN
    case (mode)
      MUL_TC: begin
        if (product[2*WIDTH-1:FRAC+WIDTH-1] != {(WIDTH-FRAC+1){product[2*WIDTH-1]}}) begin
          overflow = 1'b1;
          fixed    = product[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
      end
      MUL_SM: begin
        if (acc[2*WIDTH-2:FRAC+WIDTH-1] != '0) begin
          overflow = 1'b1;
          fixed    = {sign_in, {(WIDTH-1){1'b1}}};
        end
      end
      default: begin
        if (acc[2*WIDTH-1:FRAC+WIDTH] != '0) begin
          overflow = 1'b1;
          fixed    = '1;
        end
      end
    endcase
`endif
  end

endmodule

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - sequential shift-add multiplier with valid/ready handshakes
// Optional fixed-point saturation: define ALU_SEQ_MUL_SAT_EN.
module alu_seq_mul
  import alu_mul_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int BPC   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   fixed,
  output logic               overflow
);

  localparam int ITER = iter_count(WIDTH, BPC);
  localparam int ITW  = $clog2(ITER + 1);

  mul_state_e         state_q, next_state;
  logic [1:0]         mode_q;
  logic               sign_q;
  logic [2*WIDTH-1:0] a_sh, acc;
  logic [WIDTH-1:0]   b_mag;
  logic [ITW-1:0]     iter_q;
  logic               load, step;

  logic [WIDTH-1:0]   mag_a_w, mag_b_w;
  logic               sign_w, ovf_w;
  logic [2*WIDTH-1:0] unused_product_in;
  logic [WIDTH-1:0]   unused_fixed_in, unused_mag_a_out, unused_mag_b_out;
  logic               unused_ovf_in, unused_sign_out;

  mul_sign_conv #(.WIDTH(WIDTH), .FRAC(FRAC)) u_conv_in (
    .mode(mode), .a(a), .b(b), .sign_in(1'b0), .acc('0),
    .mag_a(mag_a_w), .mag_b(mag_b_w), .sign_out(sign_w),
    .product(unused_product_in), .fixed(unused_fixed_in), .overflow(unused_ovf_in)
  );

  mul_sign_conv #(.WIDTH(WIDTH), .FRAC(FRAC)) u_conv_out (
    .mode(mode_q), .a('0), .b('0), .sign_in(sign_q), .acc(acc),
    .mag_a(unused_mag_a_out), .mag_b(unused_mag_b_out), .sign_out(unused_sign_out),
    .product(product), .fixed(fixed), .overflow(ovf_w)
  );

  assign overflow = ovf_w & (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          next_state = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (iter_q == ITW'(ITER - 1)) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // multiplicand is pre-shifted each step instead of shifting by iter*BPC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MUL_UNS;
      sign_q <= 1'b0;
      a_sh   <= '0;
      b_mag  <= '0;
      acc    <= '0;
      iter_q <= '0;
    end else if (load) begin
      mode_q <= mode;
      sign_q <= sign_w;
      a_sh   <= {{WIDTH{1'b0}}, mag_a_w};
      b_mag  <= mag_b_w;
      acc    <= '0;
      iter_q <= '0;
    end else if (step) begin
      acc    <= acc + a_sh * {{(2*WIDTH-BPC){1'b0}}, b_mag[BPC-1:0]};
      a_sh   <= a_sh << BPC;
      b_mag  <= b_mag >> BPC;
      iter_q <= iter_q + ITW'(1);
    end
  end

endmodule

// File: tb/tb_alu_seq_mul.sv
// tb/tb_alu_seq_mul.sv - directed self-checking bench for alu_seq_mul (BPC=1 and BPC=4 instances)
module tb_alu_seq_mul;

`ifdef ALU_SEQ_MUL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        go, rdy, sel4;
  logic [15:0] a, b;
  logic [1:0]  mode;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, overflow1;
  logic [31:0] product1;
  logic [15:0] fixed1;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, overflow4;
  logic [31:0] product4;
  logic [15:0] fixed4;

  assign in_valid1  = go & ~sel4;
  assign in_valid4  = go & sel4;
  assign out_ready1 = rdy & ~sel4;
  assign out_ready4 = rdy & sel4;

  logic        s_in_ready, s_out_valid, s_overflow;
  logic [31:0] s_product;
  logic [15:0] s_fixed;
  assign s_in_ready  = sel4 ? in_ready4  : in_ready1;
  assign s_out_valid = sel4 ? out_valid4 : out_valid1;
  assign s_overflow  = sel4 ? overflow4  : overflow1;
  assign s_product   = sel4 ? product4   : product1;
  assign s_fixed     = sel4 ? fixed4     : fixed1;

  alu_seq_mul #(.WIDTH(16), .FRAC(12), .BPC(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid1), .out_ready(out_ready1),
    .product(product1), .fixed(fixed1), .overflow(overflow1)
  );

  alu_seq_mul #(.WIDTH(16), .FRAC(12), .BPC(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a), .b(b), .mode(mode), .out_valid(out_valid4), .out_ready(out_ready4),
    .product(product4), .fixed(fixed4), .overflow(overflow4)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input bit use4, input logic [1:0] m, input logic [15:0] av,
                          input logic [15:0] bv, input int lat, input string tag);
    int n;
    sel4 = use4;
    @(negedge clk);
    mode = m; a = av; b = bv; go = 1'b1;
    chk({tag, "_in_ready"}, 32'(s_in_ready), 32'd1);
    @(negedge clk);
    go = 1'b0;
    a = ~av; b = ~bv; mode = ~m;
    n = 0;
    while (!s_out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
  endtask

  task automatic check_result(input string tag, input logic [31:0] p, input logic [15:0] f,
                              input logic ov);
    chk({tag, "_out_valid"}, 32'(s_out_valid), 32'd1);
    chk({tag, "_product"}, s_product, p);
    chk({tag, "_fixed"}, 32'(s_fixed), 32'(f));
    chk({tag, "_overflow"}, 32'(s_overflow), 32'(ov));
  endtask

  task automatic finish_op(input string tag);
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    chk({tag, "_released"}, 32'(s_out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(s_in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; rdy = 1'b0; sel4 = 1'b0;
    a = '0; b = '0; mode = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready1), 32'd1);
    chk("rst_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_product", product1, 32'd0);
    chk("rst_fixed", 32'(fixed1), 32'd0);
    chk("rst_overflow", 32'(overflow1), 32'd0);
    rst = 1'b0;

    start_op(0, 2'b00, 16'hFFFF, 16'hFFFF, 16, "uns_max");
    check_result("uns_max", 32'hFFFE0001, SAT ? 16'hFFFF : 16'hFFE0, SAT);
    finish_op("uns_max");

    start_op(0, 2'b01, 16'h8000, 16'h8000, 16, "tc_minmin");
    check_result("tc_minmin", 32'h40000000, SAT ? 16'h7FFF : 16'h0000, SAT);
    finish_op("tc_minmin");

    start_op(0, 2'b01, 16'hFFFF, 16'h0003, 16, "tc_neg");
    check_result("tc_neg", 32'hFFFFFFFD, 16'hFFFF, 1'b0);
    finish_op("tc_neg");

    start_op(0, 2'b10, 16'h1800, 16'h9000, 16, "sm_neg");
    check_result("sm_neg", 32'h81800000, 16'h9800, 1'b0);
    finish_op("sm_neg");

    start_op(0, 2'b10, 16'h8000, 16'h1234, 16, "sm_zero");
    check_result("sm_zero", 32'h00000000, 16'h0000, 1'b0);
    finish_op("sm_zero");

    start_op(0, 2'b11, 16'h0100, 16'h0300, 16, "rsv_uns");
    check_result("rsv_uns", 32'h00030000, 16'h0030, 1'b0);
    finish_op("rsv_uns");

    // stall in DONE while in_valid pulses with fresh operands
    start_op(0, 2'b00, 16'h0012, 16'h0034, 16, "stall");
    check_result("stall", 32'h000003A8, 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      a = 16'h1111 + 16'(i); b = 16'h2222; mode = 2'b01;
      go = (i % 2 == 0);
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid1), 32'd1);
      chk("stall_product", product1, 32'h000003A8);
      chk("stall_in_ready", 32'(in_ready1), 32'd0);
    end
    go = 1'b0;
    finish_op("stall");

    start_op(0, 2'b01, 16'hFFFE, 16'h0007, 16, "tc_floor");
    check_result("tc_floor", 32'hFFFFFFF2, 16'hFFFF, 1'b0);
    finish_op("tc_floor");

    // abort mid-CALC after five iterations
    sel4 = 1'b0;
    @(negedge clk);
    mode = 2'b00; a = 16'h00FF; b = 16'h00FF; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid1), 32'd0);
    chk("abort_in_ready", 32'(in_ready1), 32'd1);
    chk("abort_product", product1, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    start_op(0, 2'b00, 16'h0003, 16'h0005, 16, "post_abort");
    check_result("post_abort", 32'h0000000F, 16'h0000, 1'b0);
    finish_op("post_abort");

    start_op(0, 2'b10, 16'h7FFF, 16'h7FFF, 16, "sm_sat1");
    check_result("sm_sat1", 32'h3FFF0001, SAT ? 16'h7FFF : 16'h7FF0, SAT);
    finish_op("sm_sat1");

    start_op(1, 2'b10, 16'h7FFF, 16'h7FFF, 4, "sm_sat4");
    check_result("sm_sat4", 32'h3FFF0001, SAT ? 16'h7FFF : 16'h7FF0, SAT);
    finish_op("sm_sat4");

    start_op(1, 2'b01, 16'hFFFF, 16'h0003, 4, "tc_neg4");
    check_result("tc_neg4", 32'hFFFFFFFD, 16'hFFFF, 1'b0);
    finish_op("tc_neg4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
